// File: rtl/seven_seg_reader_pkg.sv
// Shared constants and types for the seven-segment observer.
// Segment patterns are active-low, bit 0 = a ... bit 6 = g.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Indexed by hex digit; element 15 sits in the top bits.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_SETTLING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_DIGIT   = 2'd0,
    CLS_BLANK   = 2'd1,
    CLS_ILLEGAL = 2'd2
  } seg_class_e;

endpackage

// File: rtl/seven_seg_reader_if.sv
// Segment bus plus decoded results. The display side (or a bench) is the
// master; the reader is the slave.
interface seven_seg_reader_if #(
  parameter int ERR_W = 8
);
  logic [6:0]       segIn;
  logic             segStrobe;
  logic [3:0]       hexOut;
  logic             hexValid;
  logic             blank;
  logic             patErr;
  logic             digitChg;
  logic [ERR_W-1:0] errCount;

  modport master (
    output segIn, segStrobe,
    input  hexOut, hexValid, blank, patErr, digitChg, errCount
  );

  modport slave (
    input  segIn, segStrobe,
    output hexOut, hexValid, blank, patErr, digitChg, errCount
  );
endinterface

// File: rtl/seven_seg_reader_classify.sv
// seg_classify: inverse of the display decode table. Purely combinational.
module seg_classify
  import seven_seg_pkg::*;
(
  input  logic [6:0]  pat,
  output seg_class_e  cls,
  output logic [3:0]  digit
);

  // Table search; blank and legal digits are disjoint so order is irrelevant.
  always_comb begin
    cls   = CLS_ILLEGAL;
    digit = 4'h0;
    if (pat == SEG_BLANK) cls = CLS_BLANK;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_TABLE[i]) begin
        cls   = CLS_DIGIT;
        digit = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: debounces the strobed segment bus and commits the
// pattern once it has been seen STABLE_CNT strobes in a row.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  seven_seg_reader_if.slave bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  state_e           state_q, state_d;
  logic [6:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       hex_q, hex_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             perr_q, perr_d;
  logic             chg_q, chg_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [6:0]       prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;

  logic             commit;
  seg_class_e       cls;
  logic [3:0]       digit;

  // Whenever a commit happens, cand_d equals segIn, so classifying the bus
  // directly is the same as classifying the candidate being committed.
  seg_classify u_cls (
    .pat   (bus.segIn),
    .cls   (cls),
    .digit (digit)
  );

  // Next-state: stability tracking, then commit of the candidate.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    hex_d      = hex_q;
    valid_d    = valid_q;
    blank_d    = blank_q;
    err_d      = err_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    perr_d     = 1'b0;
    chg_d      = 1'b0;
    commit     = 1'b0;

    if (bus.segStrobe) begin
      unique case (state_q)
        ST_EMPTY: begin
          cand_d = bus.segIn;
          cnt_d  = 4'd1;
          if (STABLE == 4'd1) begin
            commit  = 1'b1;
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_SETTLING;
          end
        end
        ST_SETTLING: begin
          if (bus.segIn == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == STABLE) begin
              commit  = 1'b1;
              state_d = ST_LOCKED;
            end
          end else begin
            cand_d = bus.segIn;
            cnt_d  = 4'd1;
          end
        end
        ST_LOCKED: begin
          if (bus.segIn != cand_q) begin
            cand_d = bus.segIn;
            cnt_d  = 4'd1;
            if (STABLE == 4'd1) commit = 1'b1;
            else                state_d = ST_SETTLING;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    if (commit) begin
      unique case (cls)
        CLS_DIGIT: begin
          hex_d   = digit;
          valid_d = 1'b1;
          blank_d = 1'b0;
        end
        CLS_BLANK: begin
          valid_d = 1'b0;
          blank_d = 1'b1;
        end
        default: begin
          perr_d  = 1'b1;
          valid_d = 1'b0;
          blank_d = 1'b0;
          err_d   = (&err_q) ? err_q : err_q + 1'b1;
        end
      endcase
      // Full-pattern compare, so two different illegal patterns also pulse.
      chg_d      = !prev_vld_q || (bus.segIn != prev_q);
      prev_d     = bus.segIn;
      prev_vld_d = 1'b1;
    end
  end

  // State and output registers; reset wins over a same-cycle commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      cand_q     <= '0;
      cnt_q      <= '0;
      hex_q      <= '0;
      valid_q    <= 1'b0;
      blank_q    <= 1'b0;
      perr_q     <= 1'b0;
      chg_q      <= 1'b0;
      err_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      hex_q      <= hex_d;
      valid_q    <= valid_d;
      blank_q    <= blank_d;
      perr_q     <= perr_d;
      chg_q      <= chg_d;
      err_q      <= err_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign bus.hexOut   = hex_q;
  assign bus.hexValid = valid_q;
  assign bus.blank    = blank_q;
  assign bus.patErr   = perr_q;
  assign bus.digitChg = chg_q;
  assign bus.errCount = err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Bench for seven_seg_reader: two instances (STABLE_CNT 4 / ERR_W 8 and
// STABLE_CNT 1 / ERR_W 3) share one stimulus stream and are compared every
// cycle against a run-length reference model.
module tb_seven_seg_reader;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seven_seg_reader_if #(.ERR_W(8)) if0 ();
  seven_seg_reader_if #(.ERR_W(3)) if1 ();

  seven_seg_reader #(.STABLE_CNT(4), .ERR_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave)
  );
  seven_seg_reader #(.STABLE_CNT(1), .ERR_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave)
  );

  int total = 0;
  int bad   = 0;
  int chg_seen = 0;

  // Segment value for each hex digit, straight from the display table.
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int s_need [2] = '{4, 1};
  int e_max  [2] = '{255, 7};

  // Model state: length of the current run of identical strobed samples,
  // plus the expected registered outputs.
  bit         have_run [2];
  logic [6:0] run_val  [2];
  int         run_len  [2];
  bit         have_prev[2];
  logic [6:0] prev_pat [2];
  int m_hex[2], m_valid[2], m_blank[2], m_perr[2], m_chg[2], m_err[2];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Returns 0..15 for a digit, 16 for blank, -1 for illegal.
  function automatic int m_class(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    if (p == 7'h7F) return 16;
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [6:0] seg, input logic stb, input logic rn);
    int c;
    m_perr[k] = 0;
    m_chg[k]  = 0;
    if (!rn) begin
      have_run[k] = 0; run_len[k] = 0; have_prev[k] = 0;
      m_hex[k] = 0; m_valid[k] = 0; m_blank[k] = 0; m_err[k] = 0;
    end else if (stb) begin
      if (have_run[k] && seg == run_val[k]) run_len[k]++;
      else begin
        have_run[k] = 1; run_val[k] = seg; run_len[k] = 1;
      end
      if (run_len[k] == s_need[k]) begin
        c = m_class(seg);
        if (c >= 0 && c < 16) begin
          m_hex[k] = c; m_valid[k] = 1; m_blank[k] = 0;
        end else if (c == 16) begin
          m_valid[k] = 0; m_blank[k] = 1;
        end else begin
          m_perr[k] = 1; m_valid[k] = 0; m_blank[k] = 0;
          if (m_err[k] < e_max[k]) m_err[k]++;
        end
        m_chg[k] = (!have_prev[k] || seg != prev_pat[k]) ? 1 : 0;
        have_prev[k] = 1;
        prev_pat[k]  = seg;
      end
    end
  endtask

  task automatic check_all();
    chk("d0.hexOut",   int'(if0.hexOut),   m_hex[0]);
    chk("d0.hexValid", int'(if0.hexValid), m_valid[0]);
    chk("d0.blank",    int'(if0.blank),    m_blank[0]);
    chk("d0.patErr",   int'(if0.patErr),   m_perr[0]);
    chk("d0.digitChg", int'(if0.digitChg), m_chg[0]);
    chk("d0.errCount", int'(if0.errCount), m_err[0]);
    chk("d1.hexOut",   int'(if1.hexOut),   m_hex[1]);
    chk("d1.hexValid", int'(if1.hexValid), m_valid[1]);
    chk("d1.blank",    int'(if1.blank),    m_blank[1]);
    chk("d1.patErr",   int'(if1.patErr),   m_perr[1]);
    chk("d1.digitChg", int'(if1.digitChg), m_chg[1]);
    chk("d1.errCount", int'(if1.errCount), m_err[1]);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic [6:0] seg, input logic stb, input logic rn);
    if0.segIn = seg; if0.segStrobe = stb;
    if1.segIn = seg; if1.segStrobe = stb;
    reset_n = rn;
    @(posedge clk);
    model_step(0, seg, stb, rn);
    model_step(1, seg, stb, rn);
    #1;
    if (if0.digitChg) chg_seen++;
    check_all();
  endtask

  task automatic hold(input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) step(seg, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    step(7'h7F, 1'b1, 1'b0);
    step(7'h7F, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] v;
    int n;
    if0.segIn = '0; if0.segStrobe = 1'b0;
    if1.segIn = '0; if1.segStrobe = 1'b0;
    reset_n = 1'b0;

    // Reset state, including a strobe during reset that must be ignored.
    do_reset();
    chk("reset.hexValid", int'(if0.hexValid), 0);

    // Sweep 0..F, four strobes each: one digitChg per digit.
    chg_seen = 0;
    for (int d = 0; d < 16; d++) hold(tbl[d], 4);
    chk("sweep.hexOut", int'(if0.hexOut), 15);
    chk("sweep.chg_count", chg_seen, 16);

    // Glitch: 5 never settles, 4 commits on its fourth strobe.
    do_reset();
    hold(7'h12, 3);
    hold(7'h19, 3);
    chk("glitch.hex_before", int'(if0.hexOut), 0);
    chk("glitch.valid_before", int'(if0.hexValid), 0);
    hold(7'h19, 1);
    chk("glitch.hex_after", int'(if0.hexOut), 4);

    // Illegal pattern then blank then 0.
    hold(7'h7E, 4);
    chk("illegal.errCount", int'(if0.errCount), 1);
    chk("illegal.hexOut", int'(if0.hexOut), 4);
    hold(7'h7F, 5);
    chk("blank.blank", int'(if0.blank), 1);
    hold(7'h40, 4);
    chk("zero.hexValid", int'(if0.hexValid), 1);

    // Strobe gap does not break stability; re-holding 3 gives no pulse.
    hold(7'h30, 3);
    for (int i = 0; i < 10; i++) step(7'h55, 1'b0, 1'b1);
    hold(7'h30, 1);
    chk("gap.hexOut", int'(if0.hexOut), 3);
    chg_seen = 0;
    hold(7'h30, 6);
    chk("gap.no_rechg", chg_seen, 0);

    // Reset mid-settle, then a fresh four-strobe requirement.
    hold(7'h79, 2);
    do_reset();
    hold(7'h79, 3);
    chk("rst.not_yet", int'(if0.hexValid), 0);
    hold(7'h79, 1);
    chk("rst.commit", int'(if0.hexOut), 1);

    // Alternating illegal patterns drive errCount into saturation.
    for (int i = 0; i < 260; i++) hold((i % 2) ? 7'h7D : 7'h7E, 4);
    chk("sat.errCount", int'(if0.errCount), 255);
    chk("sat.errCount1", int'(if1.errCount), 7);

    // Random segments: mostly legal, some blank, some arbitrary values;
    // random holds, strobe gaps and occasional resets.
    for (int r = 0; r < 300; r++) begin
      n = $urandom_range(0, 9);
      if (n < 6)       v = tbl[$urandom_range(0, 15)];
      else if (n == 6) v = 7'h7F;
      else             v = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        step(v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
